// File: rtl/decode_stage_if.sv
// Fetch-side and execute-side channels of the decode stage, bundled for one port.
// Handshake: a transfer happens on a rising edge where valid and ready are both 1;
// the source holds valid and its payload steady until that edge, and ready never depends on valid.
interface decode_stage_if #(
  parameter int XLEN = 32
);
  logic            in_valid;
  logic            in_ready;
  logic [31:0]     in_inst;
  logic [XLEN-1:0] in_pc;

  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_pc;
  logic [4:0]      out_rs1;
  logic [4:0]      out_rs2;
  logic [4:0]      out_rd;
  logic [2:0]      out_func3;
  logic [XLEN-1:0] out_imm;
  logic [3:0]      out_alu_op;
  logic [9:0]      out_class;
  logic            out_illegal;

  modport slave (
    input  in_valid, in_inst, in_pc, out_ready,
    output in_ready, out_valid, out_pc, out_rs1, out_rs2, out_rd, out_func3,
           out_imm, out_alu_op, out_class, out_illegal
  );

  modport master (
    output in_valid, in_inst, in_pc, out_ready,
    input  in_ready, out_valid, out_pc, out_rs1, out_rs2, out_rd, out_func3,
           out_imm, out_alu_op, out_class, out_illegal
  );
endinterface

// File: rtl/decode_stage.sv
// RV32I/RV64I decode stage: decodes the incoming word combinationally and stores the
// finished bundle in a 2-entry FIFO whose head drives every out_* signal.
module decode_stage #(
  parameter int XLEN    = 32,
  parameter int SHAMT_W = $clog2(XLEN)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  decode_stage_if.slave bus
);
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_CSR    = 7'b1110011;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic [2:0]      func3;
    logic [XLEN-1:0] imm;
    logic [3:0]      alu_op;
    logic [9:0]      cls;
    logic            illegal;
  } bundle_t;

  logic [31:0] w_inst;
  logic [6:0]  w_opcode;
  logic [2:0]  w_func3;
  logic [6:0]  w_func7;
  logic        w_shift;
  logic        w_bad;
  bundle_t     w_dec;

  assign w_inst   = bus.in_inst;
  assign w_opcode = w_inst[6:0];
  assign w_func3  = w_inst[14:12];
  assign w_func7  = w_inst[31:25];
  assign w_shift  = (w_func3 == 3'b001) || (w_func3 == 3'b101);

  always_comb begin
    w_bad          = 1'b0;
    w_dec          = '0;
    w_dec.pc       = bus.in_pc;
    w_dec.rs1      = w_inst[19:15];
    w_dec.rs2      = w_inst[24:20];
    w_dec.rd       = w_inst[11:7];
    w_dec.func3    = w_func3;
    case (w_opcode)
      OP_R: begin
        w_dec.cls[0] = 1'b1;
        w_dec.alu_op = {w_inst[30], w_func3};
        if (w_func7 != 7'b0000000 && w_func7 != 7'b0100000) w_bad = 1'b1;
        if (w_func7 == 7'b0100000 && w_func3 != 3'b000 && w_func3 != 3'b101) w_bad = 1'b1;
      end
      OP_IMM: begin
        w_dec.cls[1] = 1'b1;
        w_dec.alu_op = (w_func3 == 3'b101) ? {w_inst[30], w_func3} : {1'b0, w_func3};
        if (w_shift) w_dec.imm = XLEN'(w_inst[20 +: SHAMT_W]);
        else         w_dec.imm = XLEN'($signed(w_inst[31:20]));
        if (w_func3 == 3'b001 && w_inst[31:26] != 6'b000000) w_bad = 1'b1;
        if (w_func3 == 3'b101 && w_inst[31:26] != 6'b000000 &&
            w_inst[31:26] != 6'b010000) w_bad = 1'b1;
        // On RV32 the shift amount is only 5 bits, so bit 25 must be clear.
        if (XLEN == 32 && w_shift && w_inst[25]) w_bad = 1'b1;
      end
      OP_LOAD: begin
        w_dec.cls[2] = 1'b1;
        w_dec.imm    = XLEN'($signed(w_inst[31:20]));
      end
      OP_LUI: begin
        w_dec.cls[3] = 1'b1;
        w_dec.imm    = XLEN'($signed({w_inst[31:12], 12'b0}));
      end
      OP_STORE: begin
        w_dec.cls[4] = 1'b1;
        w_dec.imm    = XLEN'($signed({w_inst[31:25], w_inst[11:7]}));
      end
      OP_BRANCH: begin
        w_dec.cls[5] = 1'b1;
        w_dec.alu_op = 4'b1000;
        w_dec.imm    = XLEN'($signed({w_inst[31], w_inst[7], w_inst[30:25], w_inst[11:8], 1'b0}));
      end
      OP_JAL: begin
        w_dec.cls[6] = 1'b1;
        w_dec.imm    = XLEN'($signed({w_inst[31], w_inst[19:12], w_inst[20], w_inst[30:21], 1'b0}));
      end
      OP_JALR: begin
        w_dec.cls[7] = 1'b1;
        w_dec.imm    = XLEN'($signed(w_inst[31:20]));
      end
      OP_CSR: begin
        w_dec.cls[8] = 1'b1;
        w_dec.imm    = XLEN'(w_inst[19:15]);
      end
      OP_AUIPC: begin
        w_dec.cls[9] = 1'b1;
        w_dec.imm    = XLEN'($signed({w_inst[31:12], 12'b0}));
      end
      default: w_bad = 1'b1;
    endcase
    if (w_inst[1:0] != 2'b11) w_bad = 1'b1;
    // Illegal words still flow downstream, but carry no class, immediate or ALU op.
    if (w_bad) begin
      w_dec.cls    = '0;
      w_dec.imm    = '0;
      w_dec.alu_op = '0;
    end
    w_dec.illegal = w_bad;
  end

  logic [1:0] r_count;
  logic       r_rd_ptr;
  bundle_t    r_mem [2];
  logic       w_in_ready;
  logic       w_out_valid;
  logic       w_push;
  logic       w_pop;
  logic       w_wr_ptr;
  bundle_t    w_head;

  assign w_in_ready  = (r_count != 2'd2);
  assign w_out_valid = (r_count != 2'd0);
  assign w_push      = bus.in_valid & w_in_ready & ~flush;
  assign w_pop       = w_out_valid & bus.out_ready;
  // Slot after the head when one entry is held, the head slot itself when empty.
  assign w_wr_ptr    = r_rd_ptr ^ r_count[0];
  assign w_head      = r_mem[r_rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count  <= 2'd0;
      r_rd_ptr <= 1'b0;
      r_mem[0] <= '0;
      r_mem[1] <= '0;
    end else begin
      if (w_push) r_mem[w_wr_ptr] <= w_dec;
      if (w_pop)  r_rd_ptr <= ~r_rd_ptr;
      if (flush)  r_count  <= 2'd0;
      else        r_count  <= r_count + {1'b0, w_push} - {1'b0, w_pop};
    end
  end

  assign bus.in_ready    = w_in_ready;
  assign bus.out_valid   = w_out_valid;
  assign bus.out_pc      = w_head.pc;
  assign bus.out_rs1     = w_head.rs1;
  assign bus.out_rs2     = w_head.rs2;
  assign bus.out_rd      = w_head.rd;
  assign bus.out_func3   = w_head.func3;
  assign bus.out_imm     = w_head.imm;
  assign bus.out_alu_op  = w_head.alu_op;
  assign bus.out_class   = w_head.cls;
  assign bus.out_illegal = w_head.illegal;
endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage: an RV32 and an RV64 instance fed identical stimulus,
// each checked against hand-decoded expectations.
module tb_decode_stage;
  logic clk;
  logic rst;
  logic flush;
  int   checks;
  int   failures;
  logic [31:0] exp_q[$];

  decode_stage_if #(.XLEN(32)) if32();
  decode_stage_if #(.XLEN(64)) if64();

  decode_stage #(.XLEN(32)) dut32 (.clk(clk), .rst(rst), .flush(flush), .bus(if32));
  decode_stage #(.XLEN(64)) dut64 (.clk(clk), .rst(rst), .flush(flush), .bus(if64));

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // driver tasks
  task automatic set_in(input logic v, input logic [31:0] inst, input logic [63:0] pc);
    if32.in_valid = v; if32.in_inst = inst; if32.in_pc = pc[31:0];
    if64.in_valid = v; if64.in_inst = inst; if64.in_pc = pc;
  endtask

  task automatic set_rdy(input logic r);
    if32.out_ready = r;
    if64.out_ready = r;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    checks++;
    if ({if32.out_valid, if32.in_ready, if64.out_valid, if64.in_ready} !== 4'b0101) begin
      failures++;
      $display("FAIL reset_init got=%b exp=0101",
               {if32.out_valid, if32.in_ready, if64.out_valid, if64.in_ready});
    end
    checks++;
    if (if32.out_imm !== 32'h0 || if64.out_imm !== 64'h0 || if32.out_class !== 10'h0) begin
      failures++;
      $display("FAIL reset_init_payload imm32=%h imm64=%h cls=%h exp=0",
               if32.out_imm, if64.out_imm, if32.out_class);
    end
    #6 rst = 1'b0;
    step();
    set_rdy(1'b0);
    set_in(1'b1, 32'hFFF00093, 64'h100);
    step();
    set_in(1'b1, 32'h800000B7, 64'h104);
    step();
    set_in(1'b0, 32'h0, 64'h0);
    checks++;
    if (if32.in_ready !== 1'b0 || if64.in_ready !== 1'b0 || if32.out_valid !== 1'b1) begin
      failures++;
      $display("FAIL reset_prefill in_ready32=%b in_ready64=%b out_valid=%b exp=0,0,1",
               if32.in_ready, if64.in_ready, if32.out_valid);
    end
    #3 rst = 1'b1;
    #1;
    checks++;
    if ({if32.out_valid, if32.in_ready, if64.out_valid, if64.in_ready} !== 4'b0101) begin
      failures++;
      $display("FAIL reset_mid got=%b exp=0101",
               {if32.out_valid, if32.in_ready, if64.out_valid, if64.in_ready});
    end
    checks++;
    if (if32.out_imm !== 32'h0 || if64.out_imm !== 64'h0 ||
        if32.out_class !== 10'h0 || if64.out_class !== 10'h0) begin
      failures++;
      $display("FAIL reset_mid_payload imm32=%h imm64=%h cls32=%h cls64=%h exp=0",
               if32.out_imm, if64.out_imm, if32.out_class, if64.out_class);
    end
    #1 rst = 1'b0;
    step();
  endtask

  typedef struct {
    logic [31:0] inst;
    logic [31:0] imm32;
    logic [63:0] imm64;
    logic [9:0]  cls32;
    logic [9:0]  cls64;
    logic [3:0]  alu32;
    logic [3:0]  alu64;
    logic        ill32;
    logic        ill64;
    logic [4:0]  rd;
  } vec_t;

  task automatic test_decode();
    vec_t tbl[15];
    logic [31:0] pc;
    tbl = '{
      '{32'hFFF00093, 32'hFFFFFFFF, 64'hFFFFFFFFFFFFFFFF, 10'h002, 10'h002, 4'h0, 4'h0, 1'b0, 1'b0, 5'd1},
      '{32'h40105093, 32'h00000001, 64'h1,                10'h002, 10'h002, 4'hD, 4'hD, 1'b0, 1'b0, 5'd1},
      '{32'h800000B7, 32'h80000000, 64'hFFFFFFFF80000000, 10'h008, 10'h008, 4'h0, 4'h0, 1'b0, 1'b0, 5'd1},
      '{32'h03F01093, 32'h00000000, 64'h3F,               10'h000, 10'h002, 4'h0, 4'h1, 1'b1, 1'b0, 5'd1},
      '{32'h002081B3, 32'h00000000, 64'h0,                10'h001, 10'h001, 4'h0, 4'h0, 1'b0, 1'b0, 5'd3},
      '{32'h407302B3, 32'h00000000, 64'h0,                10'h001, 10'h001, 4'h8, 4'h8, 1'b0, 1'b0, 5'd5},
      '{32'h00208463, 32'h00000008, 64'h8,                10'h020, 10'h020, 4'h8, 4'h8, 1'b0, 1'b0, 5'd8},
      '{32'h0020A623, 32'h0000000C, 64'hC,                10'h010, 10'h010, 4'h0, 4'h0, 1'b0, 1'b0, 5'd12},
      '{32'hFFDFF0EF, 32'hFFFFFFFC, 64'hFFFFFFFFFFFFFFFC, 10'h040, 10'h040, 4'h0, 4'h0, 1'b0, 1'b0, 5'd1},
      '{32'h3002D073, 32'h00000005, 64'h5,                10'h100, 10'h100, 4'h0, 4'h0, 1'b0, 1'b0, 5'd0},
      '{32'hFF812083, 32'hFFFFFFF8, 64'hFFFFFFFFFFFFFFF8, 10'h004, 10'h004, 4'h0, 4'h0, 1'b0, 1'b0, 5'd1},
      '{32'h12345297, 32'h12345000, 64'h12345000,         10'h200, 10'h200, 4'h0, 4'h0, 1'b0, 1'b0, 5'd5},
      '{32'h00000000, 32'h00000000, 64'h0,                10'h000, 10'h000, 4'h0, 4'h0, 1'b1, 1'b1, 5'd0},
      '{32'h020000B3, 32'h00000000, 64'h0,                10'h000, 10'h000, 4'h0, 4'h0, 1'b1, 1'b1, 5'd1},
      '{32'hFFFFFFFF, 32'h00000000, 64'h0,                10'h000, 10'h000, 4'h0, 4'h0, 1'b1, 1'b1, 5'd31}
    };
    set_rdy(1'b0);
    for (int i = 0; i < 15; i++) begin
      pc = 32'h1000 + 32'(4 * i);
      set_in(1'b1, tbl[i].inst, {32'h0, pc});
      step();
      set_in(1'b0, 32'h0, 64'h0);
      checks++;
      if ({if32.out_valid, if32.out_illegal, if32.out_class, if32.out_alu_op, if32.out_rd, if32.out_imm} !==
          {1'b1, tbl[i].ill32, tbl[i].cls32, tbl[i].alu32, tbl[i].rd, tbl[i].imm32}) begin
        failures++;
        $display("FAIL decode32 inst=%h got v=%b ill=%b cls=%h alu=%h rd=%0d imm=%h exp ill=%b cls=%h alu=%h rd=%0d imm=%h",
                 tbl[i].inst, if32.out_valid, if32.out_illegal, if32.out_class, if32.out_alu_op, if32.out_rd,
                 if32.out_imm, tbl[i].ill32, tbl[i].cls32, tbl[i].alu32, tbl[i].rd, tbl[i].imm32);
      end
      checks++;
      if ({if64.out_valid, if64.out_illegal, if64.out_class, if64.out_alu_op, if64.out_rd, if64.out_imm} !==
          {1'b1, tbl[i].ill64, tbl[i].cls64, tbl[i].alu64, tbl[i].rd, tbl[i].imm64}) begin
        failures++;
        $display("FAIL decode64 inst=%h got v=%b ill=%b cls=%h alu=%h rd=%0d imm=%h exp ill=%b cls=%h alu=%h rd=%0d imm=%h",
                 tbl[i].inst, if64.out_valid, if64.out_illegal, if64.out_class, if64.out_alu_op, if64.out_rd,
                 if64.out_imm, tbl[i].ill64, tbl[i].cls64, tbl[i].alu64, tbl[i].rd, tbl[i].imm64);
      end
      checks++;
      if ({if32.out_rs1, if32.out_rs2, if32.out_func3, if32.out_pc, if64.out_pc} !==
          {tbl[i].inst[19:15], tbl[i].inst[24:20], tbl[i].inst[14:12], pc, 32'h0, pc}) begin
        failures++;
        $display("FAIL fields inst=%h got rs1=%0d rs2=%0d f3=%0d pc32=%h pc64=%h exp pc=%h",
                 tbl[i].inst, if32.out_rs1, if32.out_rs2, if32.out_func3, if32.out_pc, if64.out_pc, pc);
      end
      set_rdy(1'b1);
      step();
      set_rdy(1'b0);
    end
    checks++;
    if (if32.out_valid !== 1'b0 || if64.out_valid !== 1'b0) begin
      failures++;
      $display("FAIL decode_drain out_valid32=%b out_valid64=%b exp=0", if32.out_valid, if64.out_valid);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] insts[3];
    logic [31:0] exp_pc;
    logic        acc;
    insts = '{32'h002081B3, 32'h407302B3, 32'h00208463};
    set_rdy(1'b0);
    for (int i = 0; i < 3; i++) begin
      set_in(1'b1, insts[i], 64'h2000 + 64'(4 * i));
      exp_q.push_back(32'h2000 + 32'(4 * i));
      step();
    end
    checks++;
    if (if32.in_ready !== 1'b0 || if64.in_ready !== 1'b0 || if32.out_pc !== 32'h2000) begin
      failures++;
      $display("FAIL bp_full in_ready32=%b in_ready64=%b pc=%h exp=0,0,00002000",
               if32.in_ready, if64.in_ready, if32.out_pc);
    end
    step();
    checks++;
    if (if32.out_pc !== 32'h2000 || if32.out_rd !== 5'd3 || if64.out_pc !== 64'h2000 || if32.in_ready !== 1'b0) begin
      failures++;
      $display("FAIL bp_hold pc32=%h rd=%0d pc64=%h in_ready=%b exp=00002000,3,2000,0",
               if32.out_pc, if32.out_rd, if64.out_pc, if32.in_ready);
    end
    set_rdy(1'b1);
    for (int i = 0; i < 3; i++) begin
      exp_pc = exp_q.pop_front();
      checks++;
      if (if32.out_valid !== 1'b1 || if32.out_pc !== exp_pc || if64.out_valid !== 1'b1 ||
          if64.out_pc !== {32'h0, exp_pc}) begin
        failures++;
        $display("FAIL bp_order[%0d] v32=%b pc32=%h v64=%b pc64=%h exp pc=%h",
                 i, if32.out_valid, if32.out_pc, if64.out_valid, if64.out_pc, exp_pc);
      end
      acc = if32.in_valid & if32.in_ready;
      step();
      if (acc) set_in(1'b0, 32'h0, 64'h0);
    end
    set_in(1'b0, 32'h0, 64'h0);
    checks++;
    if (if32.out_valid !== 1'b0 || if64.out_valid !== 1'b0) begin
      failures++;
      $display("FAIL bp_empty out_valid32=%b out_valid64=%b exp=0", if32.out_valid, if64.out_valid);
    end
    set_rdy(1'b0);
  endtask

  task automatic test_flush();
    set_rdy(1'b0);
    set_in(1'b1, 32'h002081B3, 64'h3000);
    step();
    set_in(1'b1, 32'h407302B3, 64'h3004);
    step();
    set_in(1'b1, 32'hFFF00093, 64'h3008);
    flush = 1'b1;
    step();
    flush = 1'b0;
    set_in(1'b0, 32'h0, 64'h0);
    checks++;
    if ({if32.out_valid, if32.in_ready, if64.out_valid, if64.in_ready} !== 4'b0101) begin
      failures++;
      $display("FAIL flush_full got=%b exp=0101",
               {if32.out_valid, if32.in_ready, if64.out_valid, if64.in_ready});
    end
    step();
    checks++;
    if (if32.out_valid !== 1'b0 || if64.out_valid !== 1'b0) begin
      failures++;
      $display("FAIL flush_no_ghost out_valid32=%b out_valid64=%b exp=0", if32.out_valid, if64.out_valid);
    end
    set_in(1'b1, 32'h00208463, 64'h300C);
    step();
    set_in(1'b1, 32'h0020A623, 64'h3010);
    flush = 1'b1;
    step();
    flush = 1'b0;
    set_in(1'b0, 32'h0, 64'h0);
    checks++;
    if (if32.out_valid !== 1'b0 || if64.out_valid !== 1'b0 || if32.in_ready !== 1'b1) begin
      failures++;
      $display("FAIL flush_partial out_valid32=%b out_valid64=%b in_ready=%b exp=0,0,1",
               if32.out_valid, if64.out_valid, if32.in_ready);
    end
    set_in(1'b1, 32'hFF812083, 64'h3014);
    step();
    set_in(1'b0, 32'h0, 64'h0);
    checks++;
    if ({if32.out_valid, if32.out_pc, if32.out_imm, if32.out_class} !== {1'b1, 32'h3014, 32'hFFFFFFF8, 10'h004} ||
        {if64.out_valid, if64.out_pc, if64.out_imm} !== {1'b1, 64'h3014, 64'hFFFFFFFFFFFFFFF8}) begin
      failures++;
      $display("FAIL flush_after v=%b pc=%h imm32=%h cls=%h imm64=%h exp 1,00003014,fffffff8,004,fffffffffffffff8",
               if32.out_valid, if32.out_pc, if32.out_imm, if32.out_class, if64.out_imm);
    end
    set_rdy(1'b1);
    step();
    set_rdy(1'b0);
    checks++;
    if (if32.out_valid !== 1'b0 || if64.out_valid !== 1'b0) begin
      failures++;
      $display("FAIL flush_after_pop out_valid32=%b out_valid64=%b exp=0", if32.out_valid, if64.out_valid);
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst      = 1'b1;
    flush    = 1'b0;
    set_in(1'b0, 32'h0, 64'h0);
    set_rdy(1'b0);
    #6;
    test_reset();
    test_decode();
    test_back_to_back();
    test_flush();
    // final report
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/decode_stage.md
# decode_stage

Registered, parametrised RV32I/RV64I instruction decode stage with a two-entry output buffer and valid/ready handshakes on both sides. It sits between the fetch stage and the register-read/execute stage. It accepts one raw instruction plus PC per handshake and emits a fully decoded bundle: register indices, sign-extended immediate, ALU op, one-hot instruction class and an illegal flag. Unlike the purely combinational decoder, it adds XLEN generalisation, illegal-instruction detection, back-pressure buffering and pipeline flush.

## Interface
- XLEN, 32: datapath width, 32 or 64; sets immediate and PC width.
- SHAMT_W, derived ($clog2(XLEN)): shift-amount width, 5 or 6.

- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- flush  in  1  synchronous kill of all buffered and incoming instructions.
- in_valid  in  1  fetch presents inst/pc.
- in_ready  out  1  stage can accept; driven from registered state only.
- in_inst  in  32  raw instruction word.
- in_pc  in  XLEN  instruction address.
- out_valid  out  1  decoded bundle valid.
- out_ready  in  1  downstream accepts bundle.
- out_pc  out  XLEN  PC of bundle.
- out_rs1, out_rs2, out_rd  out  5 each  inst[19:15], inst[24:20], inst[11:7].
- out_func3  out  3  inst[14:12].
- out_imm  out  XLEN  decoded immediate, see Operation.
- out_alu_op  out  4  ALU operation code.
- out_class  out  10  one-hot: bit0 R, 1 IMM, 2 LOAD, 3 LUI, 4 STORE, 5 BRANCH, 6 JAL, 7 JALR, 8 CSR, 9 AUIPC; all-zero when illegal.
- out_illegal  out  1  instruction not decodable.

## Operation
- Opcode map: R 0110011, IMM 0010011, LOAD 0000011, LUI 0110111, STORE 0100011, BRANCH 1100011, JAL 1101111, JALR 1100111, CSR 1110011, AUIPC 0010111.
- Immediates are sign-extended from inst[31] to XLEN:
  - I (IMM, LOAD, JALR): inst[31:20].
  - S: {inst[31:25], inst[11:7]}.
  - B: {inst[31], inst[7], inst[30:25], inst[11:8], 0}.
  - U (LUI, AUIPC): {inst[31:12], 12'b0}, then sign-extended to XLEN.
  - J: {inst[31], inst[19:12], inst[20], inst[30:21], 0}.
  - CSR: zero-extended inst[19:15].
  - R and illegal: 0.
  - IMM with func3 001/101: zero-extended inst[20+SHAMT_W-1:20].
- ALU op:
  - R: {inst[30], func3}.
  - IMM: func3==101 ? {inst[30], func3} : {0, func3}.
  - BRANCH: 4'b1000.
  - Otherwise: 0000.
- Illegal when any of the following holds:
  - inst[1:0] != 11.
  - Opcode not in map.
  - R with func7 not in {0000000, 0100000}.
  - R with func7 0100000 and func3 not in {000, 101}.
  - IMM func3 001 with inst[31:26] != 0.
  - IMM func3 101 with inst[31:26] not in {000000, 010000}.
  - When XLEN=32, additionally: IMM shift with inst[25]=1.
- Illegal bundles still flow through the stage with out_illegal=1 and out_class=0.
- Buffer: 2-entry FIFO of decoded bundles with a 2-bit count (0..2).
  - Decode happens before the write, so stored entries are already decoded.
  - in_ready = (count != 2).
  - out_valid = (count != 0).
  - Head entry drives all out_* ports.
- Push when in_valid & in_ready & !flush. Pop when out_valid & out_ready.
- Push and pop in the same cycle: count unchanged, order preserved. Push at count 1 with pop lands the new entry at head next cycle.
- flush: count -> 0 next edge; a simultaneous input handshake is discarded; a simultaneous pop is still counted as consumed by downstream.

## Timing
- Latency: an instruction accepted at edge N is visible on out_* from after edge N (one cycle) when the buffer was empty.
- Throughput: one instruction per cycle while out_ready=1.
- No combinational path from out_ready to in_ready, or from in_* to out_*.
- Reset (async assert): count=0, out_valid=0, in_ready=1, and all payload registers cleared to 0. Reset mid-stream drops all entries.
- Payload of out_* is held stable while out_valid=1 and out_ready=0.
- After flush, out_valid=0 the following cycle and in_ready=1.

## Test plan
- Reset/sanity: assert rst mid-stream with 2 entries held -> out_valid=0 and in_ready=1 immediately; out_imm=0 and out_class=0.
- Immediate decode (XLEN=32): push 0xFFF00093 (addi x1,x0,-1) -> out_imm=0xFFFFFFFF, class bit1, alu_op 0000, rd=1. Push 0x40105093 (srai x1,x0,1) -> imm=1, alu_op 1101.
- XLEN=64: push 0x800000B7 (lui) -> out_imm=0xFFFFFFFF80000000. Push 0x03F01093 (slli shamt 63) -> imm=63, legal; same word at XLEN=32 -> illegal.
- Back-pressure: hold out_ready=0, push 3 instructions -> in_ready drops after 2 accepted, head payload stable. Release -> bundles emerge in order, one per cycle.
- Illegal detection: push 0x00000000, 0x0200_00B3 (func7 0000001), and 0xFFFFFFFF -> each out_illegal=1, class=0.
- Flush: count=2 with a simultaneous push and flush -> next cycle out_valid=0, the pushed instruction never appears, and the subsequent push decodes normally.
